// File: rtl/rc_pwm_capture_pkg.sv
// rc_pwm_capture_pkg: shared constants, register map and channel state encoding for RC PWM capture
package rc_pwm_capture_pkg;

    localparam int RC_NCH          = 6;
    localparam int RC_CLK_PER_US   = 8;
    localparam int RC_MAX_WIDTH_US = 2500;
    localparam int RC_MIN_WIDTH_US = 800;
    localparam int RC_TIMEOUT_US   = 50000;

    localparam logic [7:0] RC_PWM_PERIOD_ADDR    = 8'h09;
    localparam logic [7:0] RC_PWM_WIDTH_CH1_ADDR = 8'h0A;
    localparam logic [7:0] RC_PWM_WIDTH_CH6_ADDR = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } chan_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] width_addr(input logic [7:0] ch);
        return RC_PWM_WIDTH_CH1_ADDR + ch;
    endfunction

endpackage

// File: rtl/rc_pwm_capture_chan.sv
// rc_pwm_capture_chan: one RC PWM channel (sync, optional RC_PWM_FILTER_EN majority filter, edge detect, width FSM, timeout)
import rc_pwm_capture_pkg::*;

module rc_pwm_capture_chan #(
    parameter int MAX_WIDTH_US = RC_MAX_WIDTH_US,
    parameter int MIN_WIDTH_US = RC_MIN_WIDTH_US,
    parameter int TIMEOUT_US   = RC_TIMEOUT_US
) (
    input  logic        clk8M,
    input  logic        rst_n,
    input  logic        us_tick,
    input  logic        pwm_in,
    output logic [15:0] width,
    output logic [15:0] since_rise,
    output logic        valid,
    output logic        upd,
    output logic        period_strobe,
    output logic        timeout
);

    localparam logic [15:0] MIN_W = 16'(MIN_WIDTH_US);
    localparam logic [15:0] MAX_W = 16'(MAX_WIDTH_US);
    localparam logic [15:0] TO_W  = 16'(TIMEOUT_US);

    logic [1:0]  sync;
    logic        level;
    logic        level_d;
    logic        rise;
    logic        fall;
    chan_state_t state, state_nx;
    logic [15:0] hi_cnt, hi_nx;
    logic [15:0] since_nx;
    logic [15:0] width_nx;
    logic        armed, armed_nx;
    logic        valid_nx;
    logic        upd_nx;

    // two-stage synchronizer for the asynchronous pin
    always_ff @(posedge clk8M or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], pwm_in};
    end

`ifdef RC_PWM_FILTER_EN
    logic [2:0] hist;

    // last three synchronized samples feed a majority vote so single-cycle glitches vanish
    always_ff @(posedge clk8M or negedge rst_n) begin
        if (!rst_n) hist <= '0;
        else        hist <= {hist[1:0], sync[1]};
    end

    assign level = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign level = sync[1];
`endif

    // previous level for edge detection
    always_ff @(posedge clk8M or negedge rst_n) begin
        if (!rst_n) level_d <= 1'b0;
        else        level_d <= level;
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    // state and measurement registers
    always_ff @(posedge clk8M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hi_cnt     <= '0;
            since_rise <= '0;
            armed      <= 1'b0;
            width      <= '0;
            valid      <= 1'b0;
            upd        <= 1'b0;
        end else begin
            state      <= state_nx;
            hi_cnt     <= hi_nx;
            since_rise <= since_nx;
            armed      <= armed_nx;
            width      <= width_nx;
            valid      <= valid_nx;
            upd        <= upd_nx;
        end
    end

    // next state: a rise always restarts the measurement, even in the timeout cycle
    always_comb begin
        state_nx      = state;
        hi_nx         = hi_cnt;
        since_nx      = since_rise;
        armed_nx      = armed;
        width_nx      = width;
        valid_nx      = valid;
        upd_nx        = 1'b0;
        timeout       = armed && (since_rise == TO_W) && !rise;
        period_strobe = rise && armed;
        if (armed && us_tick) since_nx = sat_inc(since_rise);
        if (state == ST_HIGH && us_tick) hi_nx = sat_inc(hi_cnt);
        if (rise) begin
            state_nx = ST_HIGH;
            hi_nx    = '0;
            since_nx = '0;
            armed_nx = 1'b1;
        end else if (timeout) begin
            state_nx = ST_IDLE;
            hi_nx    = '0;
            since_nx = '0;
            armed_nx = 1'b0;
            width_nx = '0;
            valid_nx = 1'b0;
        end else if (fall && state == ST_HIGH) begin
            state_nx = ST_LOW;
            if (hi_cnt >= MIN_W && hi_cnt <= MAX_W) begin
                width_nx = hi_cnt;
                valid_nx = 1'b1;
                upd_nx   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc_pwm_capture.sv
// rc_pwm_capture: NCH-channel RC PWM width capture plus ch1 period; RC_PWM_FILTER_EN adds a 3-sample glitch filter
import rc_pwm_capture_pkg::*;

module rc_pwm_capture #(
    parameter int NCH          = RC_NCH,
    parameter int CLK_PER_US   = RC_CLK_PER_US,
    parameter int MAX_WIDTH_US = RC_MAX_WIDTH_US,
    parameter int MIN_WIDTH_US = RC_MIN_WIDTH_US,
    parameter int TIMEOUT_US   = RC_TIMEOUT_US
) (
    input  logic              clk8M,
    input  logic              rst_n,
    input  logic [NCH-1:0]    rc_pwm_in,
    output logic [NCH*16-1:0] width_flat,
    output logic [15:0]       pulse_period_rc,
    output logic [NCH-1:0]    chan_valid,
    output logic [NCH-1:0]    width_upd
);

    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    logic [PW-1:0]     pre_cnt;
    logic              us_tick;
    logic [NCH*16-1:0] since_flat;
    logic [NCH-1:0]    period_strobe;
    logic [NCH-1:0]    chan_timeout;

    assign us_tick = (pre_cnt == PW'(CLK_PER_US - 1));

    // free-running microsecond prescaler shared by every channel
    always_ff @(posedge clk8M or negedge rst_n) begin
        if (!rst_n) pre_cnt <= '0;
        else        pre_cnt <= us_tick ? '0 : pre_cnt + PW'(1);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        rc_pwm_capture_chan #(
            .MAX_WIDTH_US (MAX_WIDTH_US),
            .MIN_WIDTH_US (MIN_WIDTH_US),
            .TIMEOUT_US   (TIMEOUT_US)
        ) u_chan (
            .clk8M         (clk8M),
            .rst_n         (rst_n),
            .us_tick       (us_tick),
            .pwm_in        (rc_pwm_in[i]),
            .width         (width_flat[16*i +: 16]),
            .since_rise    (since_flat[16*i +: 16]),
            .valid         (chan_valid[i]),
            .upd           (width_upd[i]),
            .period_strobe (period_strobe[i]),
            .timeout       (chan_timeout[i])
        );
    end

    // ch1 period: elapsed time at each armed rise, cleared when ch1 times out
    always_ff @(posedge clk8M or negedge rst_n) begin
        if (!rst_n)                pulse_period_rc <= '0;
        else if (period_strobe[0]) pulse_period_rc <= since_flat[15:0];
        else if (chan_timeout[0])  pulse_period_rc <= '0;
    end

endmodule
